// File: rtl/l1_dcache_waypred.sv
// 2-way set-associative write-back L1 data cache with a per-set MRU way predictor,
// per-line fill timestamps and refresh-on-stale-hit.
module l1_dcache_waypred #(
  parameter int NUM_SETS     = 16,
  parameter int STALE_CYCLES = 64,
  parameter int TS_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_stall,
  output logic        mem_req_valid,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic [31:0] mem_resp_rdata,
  input  logic        mem_resp_valid,
  output logic [31:0] hits,
  output logic [31:0] misses,
  output logic [31:0] evictions,
  output logic [31:0] dirty_evictions,
  output logic [31:0] predictor_hits,
  output logic [31:0] predictor_misses,
  output logic [31:0] stale_events
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, ALT, WB, FILL, REFRESH} state_t;

  state_t              state_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                we_reg;
  logic [31:0]         wdata_reg;
  logic [3:0]          wstrb_reg;
  logic                way_reg;
  logic [NUM_SETS-1:0] mru_reg;
  logic [TS_WIDTH-1:0] now_reg;

  logic                accept;
  logic [IDX_W-1:0]    req_idx;
  logic                addr_lsb_unused;

  // Line contents of both ways of the requested set, captured at acceptance.
  logic                p_valid [2];
  logic                p_dirty [2];
  logic [TAG_W-1:0]    p_tag   [2];
  logic [31:0]         p_data  [2];
  logic [TS_WIDTH-1:0] p_ts    [2];

  logic                probe_way;
  logic                probe_hit;
  logic [TS_WIDTH-1:0] probe_age;
  logic                probe_stale;
  logic                probing;
  logic                mem_done;
  logic                need_refresh;
  logic                respond;
  logic                victim_way;
  logic [31:0]         base_data;
  logic                base_dirty;
  logic [31:0]         merged;

  logic                wr_en;
  logic                wr_dirty;
  logic [TS_WIDTH-1:0] wr_ts;

  assign accept          = (state_reg == IDLE) && req_valid;
  assign req_idx         = req_addr[IDX_W+1:2];
  assign addr_lsb_unused = ^req_addr[1:0];
  assign resp_stall      = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
      logic [31:0]         data_mem [NUM_SETS];
      logic [TS_WIDTH-1:0] ts_mem   [NUM_SETS];
      logic [NUM_SETS-1:0] valid_q;
      logic [NUM_SETS-1:0] dirty_q;
      logic [TAG_W-1:0]    tag_rd_reg;
      logic [31:0]         data_rd_reg;
      logic [TS_WIDTH-1:0] ts_rd_reg;
      logic                valid_rd_reg;
      logic                dirty_rd_reg;
      logic                way_wr;

      assign way_wr = wr_en && (probe_way == 1'(gi));

      always_ff @(posedge clk) begin
        if (way_wr) begin
          tag_mem[idx_reg]  <= tag_reg;
          data_mem[idx_reg] <= merged;
          ts_mem[idx_reg]   <= wr_ts;
        end
        if (accept) begin
          tag_rd_reg  <= tag_mem[req_idx];
          data_rd_reg <= data_mem[req_idx];
          ts_rd_reg   <= ts_mem[req_idx];
        end
      end

      always_ff @(posedge clk) begin
        if (rst_n) begin
          valid_q      <= '0;
          dirty_q      <= '0;
          valid_rd_reg <= 1'b0;
          dirty_rd_reg <= 1'b0;
        end else begin
          if (way_wr) begin
            valid_q[idx_reg] <= 1'b1;
            dirty_q[idx_reg] <= wr_dirty;
          end
          if (accept) begin
            valid_rd_reg <= valid_q[req_idx];
            dirty_rd_reg <= dirty_q[req_idx];
          end
        end
      end

      assign p_valid[gi] = valid_rd_reg;
      assign p_dirty[gi] = dirty_rd_reg;
      assign p_tag[gi]   = tag_rd_reg;
      assign p_data[gi]  = data_rd_reg;
      assign p_ts[gi]    = ts_rd_reg;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged[8*gi +: 8] = (we_reg && wstrb_reg[gi]) ? wdata_reg[8*gi +: 8]
                                                           : base_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    probing      = (state_reg == LOOKUP) || (state_reg == ALT);
    probe_way    = (state_reg == LOOKUP) ? mru_reg[idx_reg] : way_reg;
    probe_hit    = p_valid[probe_way] && (p_tag[probe_way] == tag_reg);
    probe_age    = now_reg - p_ts[probe_way];
    probe_stale  = probe_age >= TS_WIDTH'(STALE_CYCLES);
    mem_done     = ((state_reg == FILL) || (state_reg == REFRESH)) &&
                   mem_req_valid && mem_resp_valid;
    // Only clean stale lines are re-read; dirty ones are newer than memory.
    need_refresh = probing && probe_hit && probe_stale && !p_dirty[probe_way];
    respond      = (probing && probe_hit && !need_refresh) || mem_done;
    base_data    = mem_done ? mem_resp_rdata : p_data[probe_way];
    base_dirty   = mem_done ? 1'b0 : p_dirty[probe_way];
    wr_en        = respond && !rst_n;
    wr_dirty     = base_dirty || we_reg;
    wr_ts        = (mem_done || probe_stale) ? now_reg : p_ts[probe_way];
    if (!p_valid[0]) begin
      victim_way = 1'b0;
    end else if (!p_valid[1]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = ~mru_reg[idx_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg        <= IDLE;
      tag_reg          <= '0;
      idx_reg          <= '0;
      we_reg           <= 1'b0;
      wdata_reg        <= '0;
      wstrb_reg        <= '0;
      way_reg          <= 1'b0;
      mru_reg          <= '0;
      now_reg          <= '0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_we       <= 1'b0;
      mem_req_addr     <= '0;
      mem_req_wdata    <= '0;
      hits             <= '0;
      misses           <= '0;
      evictions        <= '0;
      dirty_evictions  <= '0;
      predictor_hits   <= '0;
      predictor_misses <= '0;
      stale_events     <= '0;
    end else begin
      now_reg    <= now_reg + 1'b1;
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            tag_reg   <= req_addr[31:IDX_W+2];
            idx_reg   <= req_idx;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            wstrb_reg <= req_wstrb;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP, ALT: begin
          if (probe_hit) begin
            hits <= hits + 32'd1;
            if (state_reg == LOOKUP) predictor_hits <= predictor_hits + 32'd1;
            if (probe_stale) stale_events <= stale_events + 32'd1;
            if (need_refresh) begin
              way_reg   <= probe_way;
              state_reg <= REFRESH;
            end
          end else if (state_reg == LOOKUP) begin
            predictor_misses <= predictor_misses + 32'd1;
            way_reg          <= ~probe_way;
            state_reg        <= ALT;
          end else begin
            misses  <= misses + 32'd1;
            way_reg <= victim_way;
            if (p_valid[victim_way]) evictions <= evictions + 32'd1;
            if (p_valid[victim_way] && p_dirty[victim_way]) begin
              dirty_evictions <= dirty_evictions + 32'd1;
              state_reg       <= WB;
            end else begin
              state_reg <= FILL;
            end
          end
        end
        WB: begin
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {p_tag[way_reg], idx_reg, 2'b00};
            mem_req_wdata <= p_data[way_reg];
          end else if (mem_resp_valid) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            state_reg     <= FILL;
          end
        end
        FILL, REFRESH: begin
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {tag_reg, idx_reg, 2'b00};
          end else if (mem_resp_valid) begin
            mem_req_valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Completion of any path: line already written this edge, answer the CPU.
      if (respond) begin
        resp_valid       <= 1'b1;
        resp_rdata       <= merged;
        mru_reg[idx_reg] <= probe_way;
        state_reg        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache_waypred.sv
// Directed bench for l1_dcache_waypred with a fixed-latency backing memory model.
module tb_l1_dcache_waypred;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_stall;
  logic        mem_req_valid;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_valid;
  logic [31:0] hits, misses, evictions, dirty_evictions;
  logic [31:0] predictor_hits, predictor_misses, stale_events;

  always #5 clk = ~clk;

  l1_dcache_waypred #(.NUM_SETS(16), .STALE_CYCLES(64), .TS_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_stall(resp_stall),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_rdata(mem_resp_rdata),
    .mem_resp_valid(mem_resp_valid),
    .hits(hits), .misses(misses), .evictions(evictions), .dirty_evictions(dirty_evictions),
    .predictor_hits(predictor_hits), .predictor_misses(predictor_misses),
    .stale_events(stale_events)
  );

  // Backing memory: untouched words read as 0xA5A50000 | word_index.
  logic [31:0] mem         [1024];
  logic        mem_written [1024];
  int          lat_cnt, mem_seq, mem_rd_cnt, mem_wr_cnt, wr_seq, rd_seq;
  logic [31:0] last_wr_addr, last_wr_data, last_rd_addr;

  always @(posedge clk) begin
    if (rst_n) begin
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
      lat_cnt        <= 0;
      mem_seq        <= 0;
      mem_rd_cnt     <= 0;
      mem_wr_cnt     <= 0;
      wr_seq         <= 0;
      rd_seq         <= 0;
      last_wr_addr   <= '0;
      last_wr_data   <= '0;
      last_rd_addr   <= '0;
      for (int i = 0; i < 1024; i++) mem_written[i] <= 1'b0;
    end else if (mem_resp_valid) begin
      mem_resp_valid <= 1'b0;
    end else if (mem_req_valid) begin
      if (lat_cnt == 2) begin
        lat_cnt        <= 0;
        mem_resp_valid <= 1'b1;
        mem_seq        <= mem_seq + 1;
        if (mem_req_we) begin
          mem[mem_req_addr[11:2]]         <= mem_req_wdata;
          mem_written[mem_req_addr[11:2]] <= 1'b1;
          mem_wr_cnt   <= mem_wr_cnt + 1;
          last_wr_addr <= mem_req_addr;
          last_wr_data <= mem_req_wdata;
          wr_seq       <= mem_seq;
        end else begin
          mem_resp_rdata <= mem_written[mem_req_addr[11:2]] ? mem[mem_req_addr[11:2]]
                                                            : (32'hA5A50000 | {22'd0, mem_req_addr[11:2]});
          mem_rd_cnt   <= mem_rd_cnt + 1;
          last_rd_addr <= mem_req_addr;
          rd_seq       <= mem_seq;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    n = 0;
    while (resp_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 300);
    check("resp_seen", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    $display("txn we=%0d addr=0x%08h wdata=0x%08h wstrb=%b rdata=0x%08h lat=%0d",
             we, addr, wdata, wstrb, rdata, lat);
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    // Reset state
    do_reset();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_stall", 32'(resp_stall), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_we", 32'(mem_req_we), 32'd0);
    check("rst_hits", hits, 32'd0);
    check("rst_misses", misses, 32'd0);

    // Cold miss, then predicted hit, then partial write hit
    do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("miss_rdata", rd, 32'hA5A50040);
    check("miss_misses", misses, 32'd1);
    check("miss_pred_misses", predictor_misses, 32'd1);
    check("miss_hits", hits, 32'd0);
    check("miss_mem_reads", 32'(mem_rd_cnt), 32'd1);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("phit_lat", 32'(lat), 32'd1);
    check("phit_rdata", rd, 32'hA5A50040);
    check("phit_hits", hits, 32'd1);
    check("phit_pred_hits", predictor_hits, 32'd1);
    check("phit_stale", stale_events, 32'd0);
    do_req(1'b1, 32'h100, 32'h11223344, 4'b0011, rd, lat);
    check("wr_merged", rd, 32'hA5A53344);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("wr_readback", rd, 32'hA5A53344);
    check("wr_mem_reads", 32'(mem_rd_cnt), 32'd1);
    check("wr_mem_writes", 32'(mem_wr_cnt), 32'd0);

    // Alternate-way hit and non-MRU victim selection
    do_reset();
    do_req(1'b0, 32'h000, 32'h0, 4'h0, rd, lat);
    do_req(1'b0, 32'h040, 32'h0, 4'h0, rd, lat);
    check("fill_040_rdata", rd, 32'hA5A50010);
    do_req(1'b0, 32'h000, 32'h0, 4'h0, rd, lat);
    check("alt_lat", 32'(lat), 32'd2);
    check("alt_rdata", rd, 32'hA5A50000);
    check("alt_pred_misses", predictor_misses, 32'd3);
    check("alt_hits", hits, 32'd1);
    do_req(1'b0, 32'h080, 32'h0, 4'h0, rd, lat);
    check("evict_rdata", rd, 32'hA5A50020);
    check("evict_count", evictions, 32'd1);
    check("evict_dirty", dirty_evictions, 32'd0);
    do_req(1'b0, 32'h000, 32'h0, 4'h0, rd, lat);
    check("survivor_lat", 32'(lat), 32'd2);
    check("survivor_mem_reads", 32'(mem_rd_cnt), 32'd3);
    do_req(1'b0, 32'h040, 32'h0, 4'h0, rd, lat);
    check("victim_refetch", 32'(mem_rd_cnt), 32'd4);
    check("victim_misses", misses, 32'd4);

    // Dirty eviction writes back merged data before the fill
    do_reset();
    do_req(1'b1, 32'h100, 32'h11223344, 4'b0011, rd, lat);
    check("wa_merged", rd, 32'hA5A53344);
    do_req(1'b0, 32'h500, 32'h0, 4'h0, rd, lat);
    check("fill_500_rdata", rd, 32'hA5A50140);
    do_req(1'b0, 32'h900, 32'h0, 4'h0, rd, lat);
    check("fill_900_rdata", rd, 32'hA5A50240);
    check("wb_count", 32'(mem_wr_cnt), 32'd1);
    check("wb_addr", last_wr_addr, 32'h100);
    check("wb_data", last_wr_data, 32'hA5A53344);
    check("wb_before_fill", 32'(wr_seq < rd_seq), 32'd1);
    check("wb_dirty_evictions", dirty_evictions, 32'd1);
    check("wb_evictions", evictions, 32'd1);
    do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check("wb_refetch_rdata", rd, 32'hA5A53344);
    check("wb_no_extra_write", 32'(mem_wr_cnt), 32'd1);

    // Stale hit: clean line refreshes from memory, dirty line does not
    do_reset();
    do_req(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    repeat (70) @(negedge clk);
    do_req(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    check("stale_clean_rdata", rd, 32'hA5A50080);
    check("stale_clean_events", stale_events, 32'd1);
    check("stale_clean_refresh", 32'(mem_rd_cnt), 32'd2);
    check("stale_clean_refresh_addr", last_rd_addr, 32'h200);
    check("stale_clean_hits", hits, 32'd1);
    check("stale_clean_misses", misses, 32'd1);
    do_req(1'b1, 32'h200, 32'hDEADBEEF, 4'b1111, rd, lat);
    check("fresh_write_rdata", rd, 32'hDEADBEEF);
    check("fresh_write_stale", stale_events, 32'd1);
    repeat (70) @(negedge clk);
    do_req(1'b0, 32'h200, 32'h0, 4'h0, rd, lat);
    check("stale_dirty_lat", 32'(lat), 32'd1);
    check("stale_dirty_rdata", rd, 32'hDEADBEEF);
    check("stale_dirty_events", stale_events, 32'd2);
    check("stale_dirty_no_read", 32'(mem_rd_cnt), 32'd2);
    check("stale_dirty_hits", hits, 32'd3);
    check("pred_balance", predictor_hits + predictor_misses, hits + misses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
